// File: rtl/axi_lbus_fifo_wptr_full_pkg.sv
// Shared Gray/binary helpers and pointer-width derivation
// for the async FIFO pointer logic.
package axi_lbus_fifo_wptr_full_pkg;

   localparam int GW = 32;

   function automatic int ptr_width(input int aw);
      return aw + 1;
   endfunction

   function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Prefix XOR from the MSB down.
   function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
      logic [GW-1:0] b;
      b[GW-1] = g[GW-1];
      for (int i = GW-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/axi_lbus_fifo_gray2bin.sv
// Combinational Gray-to-binary pointer converter, shared by
// the write-side full logic and the read-side empty logic.
module axi_lbus_fifo_gray2bin
   import axi_lbus_fifo_wptr_full_pkg::*;
#(
   parameter int ADDRWIDTH = 3
) (
   input  logic [ADDRWIDTH:0] i_gray,
   output logic [ADDRWIDTH:0] o_bin
);

   localparam int PW = ptr_width(ADDRWIDTH);

   logic [GW-1:0] w_bin_wide;

   assign w_bin_wide = gray2bin(GW'(i_gray));
   assign o_bin      = w_bin_wide[PW-1:0];

endmodule

// File: rtl/axi_lbus_fifo_wptr_full.sv
// Write-domain pointer and full/almost-full/overflow flag logic
// for an async FIFO; no RAM and no synchronizers live here.
module axi_lbus_fifo_wptr_full
   import axi_lbus_fifo_wptr_full_pkg::*;
#(
   parameter int ADDRWIDTH    = 3,
   parameter int AFULL_THRESH = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [ADDRWIDTH:0]   rd_ptr_gray_sync,
   output logic [ADDRWIDTH:0]   wr_ptr_gray,
   output logic [ADDRWIDTH-1:0] wr_addr,
   output logic                 wr_we,
   output logic                 full,
   output logic                 afull,
   output logic                 overflow,
   output logic [ADDRWIDTH:0]   wr_cnt
);

   localparam int PW = ptr_width(ADDRWIDTH);
   localparam logic [PW-1:0] AF_LVL = PW'(AFULL_THRESH);

   logic [PW-1:0] r_wbin;
   logic [PW-1:0] r_gray;
   logic [PW-1:0] r_cnt;
   logic          r_full;
   logic          r_afull;
   logic          r_ovf;

   logic [PW-1:0] w_wbin_next;
   logic [GW-1:0] w_gray_wide;
   logic [PW-1:0] w_gray_next;
   logic [PW-1:0] w_rbin;
   logic [PW-1:0] w_rgray_full;
   logic [PW-1:0] w_cnt_next;

   axi_lbus_fifo_gray2bin #(
      .ADDRWIDTH (ADDRWIDTH)
   ) u_rd_g2b (
      .i_gray (rd_ptr_gray_sync),
      .o_bin  (w_rbin)
   );

   assign wr_we       = wr_en & ~r_full & ~rst;
   assign w_wbin_next = r_wbin + {{(PW-1){1'b0}}, wr_we};
   assign w_gray_wide = bin2gray(GW'(w_wbin_next));
   assign w_gray_next = w_gray_wide[PW-1:0];
   assign w_cnt_next  = w_wbin_next - w_rbin;

   // Full when the write pointer is exactly one lap ahead of the read pointer.
   assign w_rgray_full = {~rd_ptr_gray_sync[ADDRWIDTH:ADDRWIDTH-1],
                          rd_ptr_gray_sync[ADDRWIDTH-2:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wbin  <= '0;
         r_gray  <= '0;
         r_cnt   <= '0;
         r_full  <= 1'b0;
         r_afull <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_wbin  <= w_wbin_next;
         r_gray  <= w_gray_next;
         r_cnt   <= w_cnt_next;
         r_full  <= (w_gray_next == w_rgray_full);
         r_afull <= (w_cnt_next >= AF_LVL);
         r_ovf   <= wr_en & r_full;
      end
   end

   assign wr_ptr_gray = r_gray;
   assign wr_addr     = r_wbin[ADDRWIDTH-1:0];
   assign full        = r_full;
   assign afull       = r_afull;
   assign overflow    = r_ovf;
   assign wr_cnt      = r_cnt;

endmodule
